// File: rtl/debouncer_pkg.sv
// Shared limits and helpers for the multi-channel debouncer.
// Convert a stable time in microseconds to a limit value with us_to_limit().
package debouncer_pkg;

    localparam int unsigned MAX_CHANNELS    = 32;
    localparam int unsigned MAX_WIDTH       = 24;
    localparam int unsigned MIN_WIDTH       = 2;
    localparam int unsigned DEFAULT_CLK_MHZ = 100;

    // Stable time of us microseconds at clk_mhz becomes (us * clk_mhz - 1) cycles.
    function automatic int unsigned us_to_limit(input int unsigned us,
                                                input int unsigned clk_mhz);
        int unsigned cycles;
        cycles = us * clk_mhz;
        return (cycles == 0) ? 0 : cycles - 1;
    endfunction

    function automatic bit limit_fits(input int unsigned limit_val,
                                      input int unsigned width);
        return (width >= 32) || (limit_val < (32'd1 << width));
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, mismatch counter and filtered state.
// Registered rise/fall pulses exist only when DEBOUNCE_EDGE_EN is defined.
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          RESET_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [WIDTH-1:0] limit,
    output logic             dout,
    output logic             rise,
    output logic             fall
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("debounce_channel: WIDTH out of range");
    end

    logic             sync0_q;
    logic             sync1_q;
    logic             dout_q;
    logic             dout_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // >= rather than == so a limit lowered below the running count fires at once.
    always_comb begin
        dout_d = dout_q;
        cnt_d  = cnt_q;
        if (dout_q == sync1_q) begin
            cnt_d = '0;
        end else if (cnt_q >= limit) begin
            dout_d = ~dout_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q <= RESET_BIT;
            sync1_q <= RESET_BIT;
            dout_q  <= RESET_BIT;
            cnt_q   <= '0;
        end else begin
            sync0_q <= din;
            sync1_q <= sync0_q;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = dout_q;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Pulses land in the same cycle as the new dout value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= dout_d & ~dout_q;
            fall_q <= ~dout_d & dout_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer with a shared runtime stable-time limit.
// Define DEBOUNCE_EDGE_EN to get registered rise/fall pulses; otherwise they tie to 0.
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int unsigned          CHANNELS  = 8,
    parameter int unsigned          WIDTH     = 16,
    parameter logic [CHANNELS-1:0]  RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] din,
    input  logic [WIDTH-1:0]    limit,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("debouncer_multi: CHANNELS out of range");
    end

    for (genvar n = 0; n < int'(CHANNELS); n++) begin : g_ch
        debounce_channel #(
            .WIDTH     (WIDTH),
            .RESET_BIT (RESET_VAL[n])
        ) u_channel (
            .clk   (clk),
            .rst   (rst),
            .din   (din[n]),
            .limit (limit),
            .dout  (dout[n]),
            .rise  (rise[n]),
            .fall  (fall[n])
        );
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Self-checking bench for debouncer_multi (4 channels, 8-bit limit, reset level 4'b0101).
// Expected dout/rise/fall per cycle are queued by each scenario and checked on the falling edge.
module tb_debouncer_multi;

    localparam logic [3:0] RstVal = 4'b0101;
`ifdef DEBOUNCE_EDGE_EN
    localparam logic [3:0] EdgeMask = 4'hf;
`else
    localparam logic [3:0] EdgeMask = 4'h0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [7:0] limit;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;

    typedef struct {
        int         cyc;
        logic [3:0] dout;
        logic [3:0] rise;
        logic [3:0] fall;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         lim = 3;
    logic [3:0] exp_dout = RstVal;

    debouncer_multi #(
        .CHANNELS  (4),
        .WIDTH     (8),
        .RESET_VAL (RstVal)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .limit (limit),
        .dout  (dout),
        .rise  (rise),
        .fall  (fall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop every entry due this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc || dout !== e.dout || rise !== e.rise || fall !== e.fall) begin
                n_fail++;
                $display("FAIL %s cyc %0d (due %0d): dout=%b rise=%b fall=%b, expected dout=%b rise=%b fall=%b",
                         e.tag, cyc, e.cyc, dout, rise, fall, e.dout, e.rise, e.fall);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    task automatic expect_at(input int c, input logic [3:0] d, input logic [3:0] r,
                             input logic [3:0] f, input string tag);
        exp_t e;
        e.cyc  = c;
        e.dout = d;
        e.rise = r & EdgeMask;
        e.fall = f & EdgeMask;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Drive a held change and queue the expected response over the next hold cycles.
    task automatic push_step(input logic [3:0] nd, input int hold, input string tag);
        logic [3:0] old;
        int         c;
        old = exp_dout;
        c   = cyc;
        din = nd;
        for (int k = 1; k <= hold; k++) begin
            if (k < lim + 3)       expect_at(c + k, old, 4'b0, 4'b0, tag);
            else if (k == lim + 3) expect_at(c + k, nd, nd & ~old, old & ~nd, tag);
            else                   expect_at(c + k, nd, 4'b0, 4'b0, tag);
        end
        if (hold >= lim + 3) exp_dout = nd;
    endtask

    task automatic step_to(input logic [3:0] nd, input int hold, input string tag);
        push_step(nd, hold, tag);
        repeat (hold) @(negedge clk);
    endtask

    task automatic test_reset;
        int c;
        rst   = 1'b1;
        din   = RstVal;
        limit = 8'd3;
        lim   = 3;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dout !== RstVal || rise !== 4'b0 || fall !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_hold: dout=%b rise=%b fall=%b, expected dout=%b rise=0000 fall=0000",
                     dout, rise, fall, RstVal);
        end
        rst = 1'b0;
        c   = cyc;
        for (int k = 1; k <= 50; k++) expect_at(c + k, RstVal, 4'b0, 4'b0, "reset_release");
        repeat (50) @(negedge clk);
    endtask

    task automatic test_latency;
        int lat;
        step_to(4'b0100, 10, "latency_fall");
        lat = -1;
        push_step(4'b0101, 12, "latency_rise");
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (lat < 0 && dout[0] === 1'b1) lat = k;
        end
        n_checks++;
        if (lat != 6) begin
            n_fail++;
            $display("FAIL latency: dout[0] rose after %0d cycles, expected 6", lat);
        end
    endtask

    task automatic test_glitch;
        int c;
        // Two 3-cycle pulses split by one low cycle: counter must clear in between.
        c = cyc;
        for (int k = 1; k <= 16; k++) expect_at(c + k, 4'b0101, 4'b0, 4'b0, "glitch_reject");
        for (int k = 0; k < 16; k++) begin
            din = (k < 3 || (k >= 4 && k < 7)) ? 4'b0111 : 4'b0101;
            @(negedge clk);
        end
        // Pulse of limit+1 cycles: toggles, then the trailing low toggles it back.
        c = cyc;
        for (int k = 1; k <= 14; k++) begin
            if (k < 6)        expect_at(c + k, 4'b0101, 4'b0, 4'b0, "glitch_min");
            else if (k == 6)  expect_at(c + k, 4'b0111, 4'b0010, 4'b0, "glitch_min");
            else if (k < 10)  expect_at(c + k, 4'b0111, 4'b0, 4'b0, "glitch_min");
            else if (k == 10) expect_at(c + k, 4'b0101, 4'b0, 4'b0010, "glitch_min");
            else              expect_at(c + k, 4'b0101, 4'b0, 4'b0, "glitch_min");
        end
        for (int k = 0; k < 14; k++) begin
            din = (k < 4) ? 4'b0111 : 4'b0101;
            @(negedge clk);
        end
        step_to(4'b0111, 10, "glitch_long");
        step_to(4'b0101, 10, "glitch_restore");
    endtask

    task automatic test_limit_change;
        int c;
        limit = 8'd200;
        lim   = 200;
        c     = cyc;
        din   = 4'b1101;
        for (int k = 1; k <= 110; k++) begin
            if (k < 103)       expect_at(c + k, 4'b0101, 4'b0, 4'b0, "limit_lower");
            else if (k == 103) expect_at(c + k, 4'b1101, 4'b1000, 4'b0, "limit_lower");
            else               expect_at(c + k, 4'b1101, 4'b0, 4'b0, "limit_lower");
        end
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            if (k == 102) begin
                limit = 8'd10;
                lim   = 10;
            end
        end
        exp_dout = 4'b1101;
        limit    = 8'd0;
        lim      = 0;
        step_to(4'b0101, 6, "limit0_fall");
        step_to(4'b1101, 6, "limit0_rise");
        step_to(4'b0101, 6, "limit0_back");
    endtask

    task automatic test_multi;
        int c;
        limit = 8'd5;
        lim   = 5;
        step_to(4'b1010, 15, "multi_all");
        // Channels 0,1,3 change while channel 2 bounces in 2-cycle bursts.
        c = cyc;
        for (int k = 1; k <= 25; k++) begin
            if (k < 8)       expect_at(c + k, 4'b1010, 4'b0, 4'b0, "multi_bounce");
            else if (k == 8) expect_at(c + k, 4'b0001, 4'b0001, 4'b1010, "multi_bounce");
            else             expect_at(c + k, 4'b0001, 4'b0, 4'b0, "multi_bounce");
        end
        for (int k = 0; k < 25; k++) begin
            din = (k < 20 && (k % 4) < 2) ? 4'b0101 : 4'b0001;
            @(negedge clk);
        end
        exp_dout = 4'b0001;
    endtask

    task automatic test_async_reset;
        int c;
        limit = 8'd0;
        lim   = 0;
        step_to(4'b0000, 6, "areset_prep");
        limit = 8'hff;
        lim   = 255;
        c     = cyc;
        din   = 4'b1111;
        for (int k = 1; k <= 128; k++) expect_at(c + k, 4'b0000, 4'b0, 4'b0, "areset_count");
        repeat (128) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (dout !== RstVal || rise !== 4'b0 || fall !== 4'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: dout=%b rise=%b fall=%b, expected dout=%b rise=0000 fall=0000",
                     dout, rise, fall, RstVal);
        end
        @(negedge clk);
        n_checks++;
        if (dout !== RstVal) begin
            n_fail++;
            $display("FAIL areset_held: dout=%b, expected %b", dout, RstVal);
        end
        rst = 1'b0;
        c   = cyc;
        // Channels 1 and 3 restart counting from zero after release.
        for (int k = 1; k <= 265; k++) begin
            if (k < 258)       expect_at(c + k, 4'b0101, 4'b0, 4'b0, "areset_restart");
            else if (k == 258) expect_at(c + k, 4'b1111, 4'b1010, 4'b0, "areset_restart");
            else               expect_at(c + k, 4'b1111, 4'b0, 4'b0, "areset_restart");
        end
        repeat (265) @(negedge clk);
        exp_dout = 4'b1111;
    endtask

    initial begin
        rst   = 1'b1;
        din   = RstVal;
        limit = 8'd3;
        test_reset();
        test_latency();
        test_glitch();
        test_limit_change();
        test_multi();
        test_async_reset();
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
Parametrised multi-channel input debouncer for GPIO, limit-switch, home and e-stop inputs feeding the interface logic. Each channel has a 2-flop synchroniser, a mismatch counter with a runtime-programmable threshold, and a filtered output state. Adds async reset, a per-channel reset level, and a shared runtime limit instead of a fixed all-ones count. Optional registered edge-pulse outputs.

Parameters:
CHANNELS, 8, number of independent input channels (1..32)
WIDTH, 16, counter and limit width in bits (2..24)
RESET_VAL, 0, CHANNELS-bit vector; bit n is the reset level of channel n (sync flops and dout)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
din  input  CHANNELS  raw asynchronous inputs
limit  input  WIDTH  stable-time threshold in clk cycles minus one, shared by all channels, synchronous to clk
dout  output  CHANNELS  debounced state
rise  output  CHANNELS  one-cycle pulse on dout 0->1 (DEBOUNCE_EDGE_EN)
fall  output  CHANNELS  one-cycle pulse on dout 1->0 (DEBOUNCE_EDGE_EN)

Behaviour:
- Reset (async assert, sync release by system): sync0[n], sync1[n], dout[n] = RESET_VAL[n]; cnt[n] = 0; rise = fall = 0. No spurious edge after release when din matches RESET_VAL.
- Synchroniser: sync0 <= din; sync1 <= sync0; no other logic reads din.
- Per channel, every clk: idle = (dout == sync1).
  - idle: cnt <= 0.
  - not idle and cnt >= limit: dout <= ~dout, cnt <= 0.
  - not idle and cnt < limit: cnt <= cnt + 1.
- Comparison is >= so that lowering limit mid-count below cnt toggles on the next mismatching cycle; cnt never exceeds max(limit, previous limit) and never wraps.
- limit = 0: dout follows sync1 with 1 extra cycle (no filtering). limit = all-ones: cnt reaches 2^WIDTH-1, toggles, no overflow.
- Latency: stable din change to dout change = 2 (sync) + limit + 1 clk cycles.
- Glitch rejection: any return to idle before cnt reaches limit clears cnt; a pulse shorter than limit+1 sync1 cycles never reaches dout.
- Channels fully independent; simultaneous toggles on several channels allowed in one cycle.
- Reset mid-count: counter discarded; dout returns to RESET_VAL immediately (async).
- dout, rise, fall are all register outputs; no combinational path from din or limit to outputs.

Optional Feature:
Macro DEBOUNCE_EDGE_EN.
- Defined: rise[n] registered high for exactly one cycle in the same cycle dout[n] goes 0->1; fall[n] likewise for 1->0. Both reset to 0. Never both high on one channel.
- Undefined: rise and fall ports remain, driven constant 0; no edge registers synthesised.

Decomposition:
- Package debouncer_pkg: MAX_CHANNELS = 32, MAX_WIDTH = 24, localparam helpers for limit-from-microseconds conversion (cycles = us * CLK_MHZ - 1).
- Sub-module debounce_channel (one sync chain, counter, state, optional edge regs; WIDTH and RESET_BIT parameters), instantiated CHANNELS times by a generate loop in debouncer_multi.

Test Plan:
- Reset: CHANNELS=4, WIDTH=8, RESET_VAL=4'b0101, din=4'b0101, pulse rst -> dout=4'b0101, rise=fall=0 for 50 cycles after release.
- Latency: limit=3, din[0] 0->1 held -> dout[0] rises exactly 6 cycles after the din edge is sampled; rise[0] high for that one cycle only (edge macro on).
- Glitch: limit=3, din[1] high for 3 cycles then low -> dout[1] unchanged, cnt returns to 0; high for 4+ sync cycles -> toggles.
- Limit change: limit=200, mismatch held 100 cycles, then limit=10 -> dout toggles on the next cycle; limit=0 -> dout follows din with 3-cycle delay.
- Multi-channel: toggle all 4 inputs in the same cycle with limit=5 -> all dout bits change together, independent of other channels' bounce on channel 2.
- Async reset mid-count: limit=255, mismatch 128 cycles, assert rst between clock edges -> dout=RESET_VAL immediately, no fall/rise pulse, count restarts from 0 after release.
